// File: rtl/lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer
//
// Micro-sequencer for the Load-Multiple (LM, opcode 0110) and Store-Multiple
// (SM, opcode 0111) instructions. It sits beside decode, accepts one LM/SM
// instruction together with the RA base value, and expands the register mask
// into one register/memory transfer per set bit. Fetch is stalled until the
// sequence completes.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset (highest priority)
//   instr_valid  in   instr holds a decoded instruction this cycle
//   instr        in   [15:12] opcode, [11:9] RA, [7:0] register mask
//   base_addr    in   value of RA, valid with instr_valid
//   flush        in   synchronous abort from branch/jump resolution
//   xfer_ready   in   memory/regfile port accepts the current transfer
//   stall_fetch  out  holds PC and the fetch/decode registers
//   xfer_valid   out  a transfer is presented
//   xfer_store   out  1 = SM (reg to mem), 0 = LM (mem to reg)
//   xfer_reg     out  register index of the current transfer
//   xfer_addr    out  memory address of the current transfer
//   done         out  one-cycle pulse when the sequence completes
//   state_dbg    out  current FSM state (0 = IDLE, 1 = XFER, 2 = DONE)
//
// Transfer handshake: a transfer completes on a rising edge where
// xfer_valid=1 and xfer_ready=1 (and no flush/reset). While xfer_valid=1
// and xfer_ready=0, xfer_reg, xfer_addr and xfer_store hold stable.
// xfer_valid never drops without a completion, except on flush or reset.
//
// Mask mapping: mask bit (NUM_REGS-1) is R0, bit 0 is R(NUM_REGS-1).
// Transfers issue in ascending register order, R0 first.
// All outputs are registered, so they change only on the clock edge.
// ---------------------------------------------------------------------------
module lm_sm_sequencer #(
    parameter int ADDR_STEP = 1,
    parameter int NUM_REGS  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    input  logic [15:0] base_addr,
    input  logic        flush,
    input  logic        xfer_ready,
    output logic        stall_fetch,
    output logic        xfer_valid,
    output logic        xfer_store,
    output logic [2:0]  xfer_reg,
    output logic [15:0] xfer_addr,
    output logic        done,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] STEP = 16'(ADDR_STEP);

    // State and internal sequence registers
    state_t                state_q, state_d;
    logic [NUM_REGS-1:0]   mask_q,  mask_d;
    logic [15:0]           addr_q,  addr_d;
    logic                  kind_q,  kind_d;

    // Registered outputs
    logic                  stall_q,      stall_d;
    logic                  xfer_valid_q, xfer_valid_d;
    logic                  xfer_store_q, xfer_store_d;
    logic [2:0]            xfer_reg_q,   xfer_reg_d;
    logic [15:0]           xfer_addr_q,  xfer_addr_d;
    logic                  done_q,       done_d;

    // Decode helpers
    logic                  is_lm_sm;
    logic                  accept;
    logic [NUM_REGS-1:0]   new_mask;
    logic [NUM_REGS-1:0]   remaining;
    logic [15:0]           addr_next;

    // RA and the bits between RA and the mask are not needed here;
    // the base value arrives already read on base_addr.
    logic                  unused_instr_bits;
    assign unused_instr_bits = ^instr[11:8];

    // Lowest-numbered pending register. Register i lives in mask bit
    // (NUM_REGS-1-i); scanning from the highest index down lets the
    // lowest set register overwrite the result last.
    function automatic logic [2:0] first_reg(input logic [NUM_REGS-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (m[NUM_REGS-1-i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Mask with the bit belonging to register r cleared.
    function automatic logic [NUM_REGS-1:0] clear_reg(input logic [NUM_REGS-1:0] m,
                                                      input logic [2:0]          r);
        logic [NUM_REGS-1:0] sel;
        sel = '0;
        sel[NUM_REGS-1-int'(r)] = 1'b1;
        return m & ~sel;
    endfunction

    assign is_lm_sm  = (instr[15:13] == 3'b011);
    assign accept    = instr_valid && is_lm_sm;
    assign new_mask  = instr[NUM_REGS-1:0];
    assign remaining = clear_reg(mask_q, xfer_reg_q);
    assign addr_next = addr_q + STEP;

    always_comb begin
        // Default: hold everything
        state_d      = state_q;
        mask_d       = mask_q;
        addr_d       = addr_q;
        kind_d       = kind_q;
        stall_d      = stall_q;
        xfer_valid_d = xfer_valid_q;
        xfer_store_d = xfer_store_q;
        xfer_reg_d   = xfer_reg_q;
        xfer_addr_d  = xfer_addr_q;
        done_d       = done_q;

        if (flush) begin
            // Abort outranks accept and completion: a transfer presented
            // in this cycle is not counted, and no done pulse follows.
            state_d      = ST_IDLE;
            mask_d       = '0;
            addr_d       = '0;
            kind_d       = 1'b0;
            stall_d      = 1'b0;
            xfer_valid_d = 1'b0;
            xfer_store_d = 1'b0;
            xfer_reg_d   = '0;
            xfer_addr_d  = '0;
            done_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stall_d      = 1'b0;
                    xfer_valid_d = 1'b0;
                    xfer_store_d = 1'b0;
                    xfer_reg_d   = '0;
                    xfer_addr_d  = '0;
                    done_d       = 1'b0;
                    if (accept) begin
                        mask_d  = new_mask;
                        addr_d  = base_addr;
                        kind_d  = instr[12];
                        stall_d = 1'b1;
                        if (new_mask != '0) begin
                            state_d      = ST_XFER;
                            xfer_valid_d = 1'b1;
                            xfer_store_d = instr[12];
                            xfer_reg_d   = first_reg(new_mask);
                            xfer_addr_d  = base_addr;
                        end else begin
                            // Empty mask: nothing to transfer, finish at once.
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end

                ST_XFER: begin
                    if (xfer_ready) begin
                        mask_d = remaining;
                        addr_d = addr_next;
                        if (remaining != '0) begin
                            xfer_reg_d  = first_reg(remaining);
                            xfer_addr_d = addr_next;
                        end else begin
                            state_d      = ST_DONE;
                            xfer_valid_d = 1'b0;
                            xfer_store_d = 1'b0;
                            xfer_reg_d   = '0;
                            xfer_addr_d  = '0;
                            done_d       = 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                    stall_d = 1'b0;
                    done_d  = 1'b0;
                end

                default: begin
                    state_d      = ST_IDLE;
                    stall_d      = 1'b0;
                    xfer_valid_d = 1'b0;
                    xfer_store_d = 1'b0;
                    xfer_reg_d   = '0;
                    xfer_addr_d  = '0;
                    done_d       = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            addr_q       <= '0;
            kind_q       <= 1'b0;
            stall_q      <= 1'b0;
            xfer_valid_q <= 1'b0;
            xfer_store_q <= 1'b0;
            xfer_reg_q   <= '0;
            xfer_addr_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            addr_q       <= addr_d;
            kind_q       <= kind_d;
            stall_q      <= stall_d;
            xfer_valid_q <= xfer_valid_d;
            xfer_store_q <= xfer_store_d;
            xfer_reg_q   <= xfer_reg_d;
            xfer_addr_q  <= xfer_addr_d;
            done_q       <= done_d;
        end
    end

    assign stall_fetch = stall_q;
    assign xfer_valid  = xfer_valid_q;
    assign xfer_store  = xfer_store_q;
    assign xfer_reg    = xfer_reg_q;
    assign xfer_addr   = xfer_addr_q;
    assign done        = done_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Micro-sequencer for the Load-Multiple (LM, opcode 0110) and Store-Multiple (SM, opcode 0111) instructions in the pipelined RISC core.
- Sits beside the decode stage. Accepts one LM/SM instruction plus the RA base value read from the register file.
- Expands the 8-bit register mask into one register/memory transfer per set bit, and holds fetch stalled until the sequence completes.

Parameters:
- ADDR_STEP, default 1: address increment per transfer, in words.
- NUM_REGS, default 8: mask width and register count (fixed at 8 for this ISA; parameterised only for the bench).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instr holds a decoded instruction this cycle
- instr  in  16  instruction word; [15:12] opcode, [11:9] RA, [7:0] register mask
- base_addr  in  16  value of RA, valid with instr_valid
- flush  in  1  synchronous abort from branch/jump resolution
- xfer_ready  in  1  memory/regfile port accepts the current transfer
- stall_fetch  out  1  holds PC and the fetch/decode registers
- xfer_valid  out  1  a transfer is presented
- xfer_store  out  1  1 = SM (reg to mem), 0 = LM (mem to reg)
- xfer_reg  out  3  register index for the transfer
- xfer_addr  out  16  memory address for the transfer
- done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset:
  - state=IDLE; all outputs 0; internal mask, address and kind registers 0.
  - Reset overrides every other input in the same cycle, including mid-sequence.
- States: IDLE, XFER, DONE.
- IDLE:
  - Accept when instr_valid=1 and instr[15:13]=011.
  - On accept, latch mask=instr[7:0], addr=base_addr, kind=instr[12].
  - Non-LM/SM instructions are ignored.
  - Accept with mask!=0 goes to XFER. Accept with mask==0 goes to DONE; no transfer is issued.
- Mask mapping: mask bit 7 = R0 ... bit 0 = R7. Transfers issue in ascending register order (R0 first).
- XFER:
  - xfer_valid=1. xfer_reg = lowest-numbered pending register. xfer_addr = current addr. xfer_store = kind.
  - A transfer completes on a cycle with xfer_valid=1 and xfer_ready=1. On completion, clear that mask bit and set addr = addr + ADDR_STEP (mod 2^16, wraps 0xFFFF to 0x0000).
  - While xfer_ready=0, xfer_reg, xfer_addr and xfer_store hold stable.
  - When the final pending bit completes, go to DONE. xfer_valid drops the next cycle.
- DONE: done=1 for exactly one cycle, then IDLE.
- stall_fetch: 1 in XFER and DONE, 0 in IDLE. It asserts the cycle after accept, because outputs are registered. Decode must treat the accept cycle itself as occupied.
- Latency:
  - Accept at edge T gives the first xfer_valid in cycle T+1.
  - With xfer_ready tied to 1, N set bits give transfers in T+1..T+N, done in T+N+1, and IDLE again at T+N+2.
- instr_valid while not in IDLE: ignored, and the instruction is not queued.
- flush:
  - Takes effect at the next edge: state goes to IDLE and all outputs go to 0, with no done pulse.
  - Ranks below reset and above accept and transfer completion.
  - flush in IDLE suppresses an accept in the same cycle.
- Simultaneous xfer_ready=1 and flush: the transfer is not counted as completed.
- Memory-side address arithmetic is 16-bit unsigned; no overflow flag.

Test Plan:
- LM, mask=8'b1010_0001, base=0x0040, xfer_ready=1 -> transfers (R0,0x0040), (R2,0x0041), (R7,0x0042), xfer_store=0; done at accept+4; stall_fetch high for cycles accept+1..accept+4.
- SM, mask=8'hFF, base=0xFFFE -> 8 transfers R0..R7 with addresses 0xFFFE, 0xFFFF, 0x0000 ... 0x0005 (wrap), xfer_store=1; single done pulse.
- LM, mask=8'h00 -> no xfer_valid; done=1 at accept+1; IDLE at accept+2.
- LM, mask=8'hC0, xfer_ready low for 3 cycles during R0 -> R0/addr held stable for 4 cycles, then R1; total 2 transfers; a second instr_valid issued mid-sequence is ignored.
- SM, mask=8'hF0 -> flush asserted during the second transfer with xfer_ready=1 -> IDLE next cycle, no done, outputs 0. In a separate run, reset asserted mid-sequence gives the same result.
- Non-LM/SM instructions (ADD 0001, BEQ 1000) with instr_valid=1 -> state stays IDLE, stall_fetch=0.
